// File: rtl/dc_sync_ctrl.sv
// Sequencer for the delay-correlate timing-metric datapath: clear, prime the delay line
// and window, detect a threshold crossing, then search a fixed window for the metric peak.
module dc_sync_ctrl #(
  parameter int DELAY    = 16,
  parameter int WIN      = 16,
  parameter int PEAK_WIN = 32,
  parameter int MAX_SRCH = 4096,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      threshold,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic             shift_en,
  output logic             dp_clr_n,
  input  logic [31:0]      metric,
  input  logic             metric_vld,
  output logic             busy,
  output logic             found,
  output logic [CNT_W-1:0] peak_idx,
  output logic [31:0]      peak_val,
  output logic             timeout
);

  // state  | meaning
  // IDLE   | waiting for start
  // CLEAR  | one-cycle synchronous clear of the DC datapath
  // FILL   | priming delay line and moving-sum window, metrics discarded
  // SEARCH | looking for the first metric >= threshold
  // PEAK   | tracking the maximum over the next PEAK_WIN metrics
  // DONE   | one cycle, found pulse, peak outputs final

  localparam int FILL_N = DELAY + WIN;

  if (MAX_SRCH + PEAK_WIN >= 2**CNT_W) begin : g_cnt_w_check
    $error("dc_sync_ctrl: CNT_W too small for MAX_SRCH + PEAK_WIN");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, SEARCH, PEAK, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   best_idx, best_idx_nxt;
  logic [31:0]        best_val, best_val_nxt;
  logic [31:0]        thr, thr_nxt;
  logic               found_nxt, timeout_nxt;

  assign s_axis_tready = (state == FILL) || (state == SEARCH) || (state == PEAK);
  assign shift_en      = s_axis_tvalid & s_axis_tready;
  assign dp_clr_n      = (state != CLEAR);
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    best_idx_nxt = best_idx;
    best_val_nxt = best_val;
    thr_nxt      = thr;
    found_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          thr_nxt   = threshold;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = FILL;
      end
      FILL: begin
        if (metric_vld) begin
          if (cnt == CNT_W'(FILL_N - 1)) begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = SEARCH;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      SEARCH: begin
        if (metric_vld) begin
          if (metric >= thr) begin
            best_val_nxt = metric;
            best_idx_nxt = idx;
            idx_nxt      = idx + 1'b1;
            cnt_nxt      = '0;
            state_nxt    = PEAK;
          end else if (idx == CNT_W'(MAX_SRCH - 1)) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      PEAK: begin
        if (metric_vld) begin
          // strict compare: a tie keeps the earliest index
          if (metric > best_val) begin
            best_val_nxt = metric;
            best_idx_nxt = idx;
          end
          idx_nxt = idx + 1'b1;
          if (cnt == CNT_W'(PEAK_WIN - 1)) begin
            found_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      best_idx <= '0;
      best_val <= '0;
      thr      <= '0;
      found    <= 1'b0;
      timeout  <= 1'b0;
      peak_idx <= '0;
      peak_val <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      best_idx <= best_idx_nxt;
      best_val <= best_val_nxt;
      thr      <= thr_nxt;
      found    <= found_nxt;
      timeout  <= timeout_nxt;
      // outputs stay at the previous result until the new peak is final
      if (found_nxt) begin
        peak_idx <= best_idx_nxt;
        peak_val <= best_val_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dc_sync_ctrl.sv
// Directed bench for dc_sync_ctrl; models the DC datapath as a one-cycle
// shift_en -> metric_vld delay with metrics taken from per-test tables.
module tb_dc_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] threshold = 32'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        shift_en;
  logic        dp_clr_n;
  logic [31:0] metric = 32'd0;
  logic        metric_vld = 1'b0;
  logic        busy;
  logic        found;
  logic [15:0] peak_idx;
  logic [31:0] peak_val;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int mode = 3;
  int sample_n = 0;

  dc_sync_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .shift_en(shift_en), .dp_clr_n(dp_clr_n), .metric(metric),
    .metric_vld(metric_vld), .busy(busy), .found(found),
    .peak_idx(peak_idx), .peak_val(peak_val), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // metric for sample n; samples 0..31 fall in the warm-up and must be ignored
  function automatic logic [31:0] mfun(int m, int n);
    int i;
    i = n - 32;
    if (n < 32) return (m == 3) ? 32'd1000 : 32'hFFFF_FFFF;
    case (m)
      2: return 32'd0;
      3: return (i == 10) ? 32'd100 : ((i == 15 || i == 20) ? 32'd300 : 32'd50);
      6: return (i == 5) ? 32'd200 : ((i == 37) ? 32'd500 : ((i == 38) ? 32'd900 : 32'd50));
      default: return 32'd50;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      metric_vld <= 1'b0;
      sample_n   <= 0;
    end else begin
      metric_vld <= shift_en;
      if (!dp_clr_n) sample_n <= 0;
      else if (shift_en) begin
        metric   <= mfun(mode, sample_n);
        sample_n <= sample_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // start pulse must already be driven; runs until the frame ends or the budget expires
  task automatic run(input int max_cyc, input bit rnd, input int start_at,
                     output int n_found, output int n_to, output int n_clr,
                     output int n_bad, output bit ended);
    n_found = 0; n_to = 0; n_clr = 0; n_bad = 0; ended = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (found) n_found++;
      if (timeout) n_to++;
      if (!dp_clr_n) n_clr++;
      if (shift_en !== (s_axis_tvalid & s_axis_tready)) n_bad++;
      start = (c == start_at);
      if (c == 1) threshold = 32'hFFFF_FFFF;
      s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!busy && (n_found + n_to) > 0) begin
        ended = 1'b1;
        break;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (found) n_found++;
      if (timeout) n_to++;
    end
  endtask

  task automatic kick(input int m, input logic [31:0] thr);
    @(negedge clk);
    mode = m;
    threshold = thr;
    s_axis_tvalid = 1'b1;
    start = 1'b1;
  endtask

  initial begin
    int nf, nt, nc, nb;
    bit en;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_clr_n", {31'd0, dp_clr_n}, 32'd1);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_peak_idx", {16'd0, peak_idx}, 32'd0);
    chk("rst_peak_val", peak_val, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // detect: equality crossing at 10, max 300 at 15, tie at 20 ignored
    kick(3, 32'd100);
    run(400, 1'b0, -1, nf, nt, nc, nb, en);
    chk("det_ended", {31'd0, en}, 32'd1);
    chk("det_found_cnt", nf, 32'd1);
    chk("det_timeout_cnt", nt, 32'd0);
    chk("det_clr_cycles", nc, 32'd1);
    chk("det_peak_idx", {16'd0, peak_idx}, 32'd15);
    chk("det_peak_val", peak_val, 32'd300);
    chk("det_idle_busy", {31'd0, busy}, 32'd0);

    // same frame with random stalls
    kick(3, 32'd100);
    run(2000, 1'b1, -1, nf, nt, nc, nb, en);
    chk("stall_found_cnt", nf, 32'd1);
    chk("stall_peak_idx", {16'd0, peak_idx}, 32'd15);
    chk("stall_peak_val", peak_val, 32'd300);
    chk("stall_shift_en", nb, 32'd0);

    // start pulsed during SEARCH is ignored
    kick(3, 32'd100);
    run(400, 1'b0, 38, nf, nt, nc, nb, en);
    chk("busy_start_found", nf, 32'd1);
    chk("busy_start_clr", nc, 32'd1);
    chk("busy_start_idx", {16'd0, peak_idx}, 32'd15);
    @(negedge clk);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // peak at the far edge of the window; the next metric lies outside
    kick(6, 32'd100);
    run(400, 1'b0, -1, nf, nt, nc, nb, en);
    chk("edge_found_cnt", nf, 32'd1);
    chk("edge_peak_idx", {16'd0, peak_idx}, 32'd37);
    chk("edge_peak_val", peak_val, 32'd500);

    // warm-up metrics all-ones ignored; nothing crosses afterwards
    kick(2, 32'd100);
    run(6000, 1'b0, -1, nf, nt, nc, nb, en);
    chk("to_ended", {31'd0, en}, 32'd1);
    chk("to_timeout_cnt", nt, 32'd1);
    chk("to_found_cnt", nf, 32'd0);
    chk("to_hold_idx", {16'd0, peak_idx}, 32'd37);
    chk("to_hold_val", peak_val, 32'd500);

    // async reset in the middle of PEAK
    kick(3, 32'd100);
    run(55, 1'b0, -1, nf, nt, nc, nb, en);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_no_found", nf, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("arst_found", {31'd0, found}, 32'd0);
    chk("arst_peak_val", peak_val, 32'd0);
    chk("arst_peak_idx", {16'd0, peak_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(40, 1'b0, -1, nf, nt, nc, nb, en);
    chk("arst_no_pulse", nf + nt, 32'd0);
    chk("arst_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
